ahb_master_if: RTL and testbench
================================

Name: ahb_master_if

Overview:
- Upstream AHB master bridge. It converts one-command-at-a-time burst requests from a local engine into pipelined AHB address/data phases (NONSEQ/SEQ/IDLE) that feed the AHB slave interface.
- It computes incrementing and wrapping burst addresses, stalls on HREADY, and aborts the burst on an ERROR response.
- Read data and completion/error status return to the local engine.

Parameters:
- AHB_DATA_WIDTH, 32, data bus width in bits (32/64).
- AHB_ADDR_WIDTH, 32, address bus width in bits.

Ports:
- ahb_clk_in  in  1  bus clock
- ahb_rstn_in  in  1  reset, asynchronous, active-low
- cmd_valid_in  in  1  command request
- cmd_ready_out  out  1  high in IDLE only; a command is accepted when valid&ready
- cmd_addr_in  in  AHB_ADDR_WIDTH  start address
- cmd_burst_in  in  3  HBURST encoding (0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16)
- cmd_len_in  in  5  beat count for INCR only (0 treated as 1, max 16)
- cmd_size_in  in  3  HSIZE
- cmd_write_in  in  1  1 = write
- wdata_in  in  AHB_DATA_WIDTH  write beat data; must be valid while wdata_ack_out can fire
- wdata_ack_out  out  1  pulse: wdata_in consumed for the next beat
- rdata_out  out  AHB_DATA_WIDTH  read beat data
- rdata_valid_out  out  1  pulse per completed read beat
- done_out  out  1  one-cycle pulse at command end
- error_out  out  1  qualifies done_out; 1 = aborted or rejected
- ahb_sel_out  out  1  HSEL
- ahb_addr_out  out  AHB_ADDR_WIDTH  HADDR
- ahb_burst_out  out  3  HBURST
- ahb_size_out  out  3  HSIZE
- ahb_trans_out  out  2  HTRANS (0 IDLE, 2 NONSEQ, 3 SEQ; BUSY never issued)
- ahb_write_out  out  1  HWRITE
- ahb_wdata_out  out  AHB_DATA_WIDTH  HWDATA
- ahb_ready_in  in  1  HREADY
- ahb_resp_in  in  1  HRESP (1 = ERROR)
- ahb_rdata_in  in  AHB_DATA_WIDTH  HRDATA

Behaviour:
- All logic runs on posedge ahb_clk_in. Asynchronous reset clears all registered outputs to 0: ahb_trans_out = IDLE, ahb_sel_out = 0, done_out = 0, error_out = 0. cmd_ready_out = 1 after reset.
- States:
  - IDLE: ready for a command.
  - ADDR: NONSEQ on bus.
  - BURST: SEQ beats.
  - LAST: final data phase; address bus IDLE.
  - ERR: second cycle of an ERROR response.
- Beats: SINGLE = 1; INCRn/WRAPn = n; INCR = cmd_len_in (0 → 1).
- Command rejection at acceptance. done_out = 1 and error_out = 1 are issued the next cycle with no bus activity if either holds:
  - (8 << size) > AHB_DATA_WIDTH.
  - Address not aligned to 1 << size.
  - An INCR-type burst's last byte crosses a 1 KB boundary (addr[10] ≠ end addr[10] or higher bits differ).
- Acceptance:
  - Next cycle, drive ahb_sel_out = 1, trans = NONSEQ, and the captured addr/burst/size/write. State → ADDR.
  - For a write, wdata_ack_out pulses in the cycle the beat's address phase completes (HREADY = 1), and ahb_wdata_out loads wdata_in on that edge.
- Address phase completes on the edge with ahb_ready_in = 1. Then:
  - More beats remain: trans = SEQ, address advances, state BURST.
  - Else: trans = IDLE, state LAST.
- Address advance is mask = (beats << size) − 1.
  - INCR types: addr + (1 << size).
  - WRAP types: (addr & ~mask) | ((addr + (1 << size)) & mask).
  - Example: WRAP4, word, start 0x38 → 0x38, 0x3C, 0x30, 0x34.
- While ahb_ready_in = 0, all address/control/wdata outputs hold.
- Data phase of beat k completes on the edge with ahb_ready_in = 1 and ahb_resp_in = 0, one beat behind the address beat.
  - Read: rdata_out ← ahb_rdata_in, with a one-cycle rdata_valid_out pulse.
- Completion: after the last data phase completes (in LAST), done_out pulses with error_out = 0. Next state IDLE, ahb_sel_out → 0, cmd_ready_out → 1.
- Error: ahb_resp_in = 1 with ahb_ready_in = 0 (first error cycle):
  - Drive trans = IDLE immediately on the next edge, cancelling remaining beats; no further wdata_ack_out.
  - State → ERR. On the following ready = 1 edge, done_out = 1 and error_out = 1, then IDLE.
  - A data beat that completes with resp = 1 produces no rdata_valid_out.
- Counters:
  - addr_cnt and data_cnt, 5 bits each, count remaining beats.
  - data_cnt reaching 0 marks completion; addr_cnt is never allowed to underflow.
- A new cmd_valid_in during any non-IDLE state is ignored (cmd_ready_out = 0).
- Reset mid-burst: outputs return to reset values immediately; no done_out is issued.

Test Plan:
- Single read: cmd (addr 0x100, size 2, SINGLE), HREADY = 1 → one NONSEQ at 0x100, then IDLE; rdata_valid_out with slave data; done_out = 1, error_out = 0 three cycles after accept.
- INCR4 write with 2-cycle wait on beat 2: addr 0x200 → HADDR 0x200/0x204/0x208/0x20C, SEQ held during the wait; four wdata_ack_out pulses; HWDATA stable during the wait.
- WRAP8 read, word, start 0x1C → addresses 0x1C, 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14, 0x18; eight rdata_valid_out pulses.
- ERROR on beat 2 of INCR8 (resp = 1, ready 0 then 1) → trans goes IDLE after the first error cycle; no further beats issued; done_out = 1 and error_out = 1; one rdata_valid_out pulse only.
- Rejections:
  - size 3 with AHB_DATA_WIDTH = 32 → done_out = 1, error_out = 1, HTRANS stays IDLE.
  - INCR16 word at 0x3F8 (crosses 1 KB) → same response.
- Async reset asserted mid INCR burst → HSEL = 0 and HTRANS = IDLE immediately; cmd_ready_out = 1 after release; no done_out.

Source files
------------

// File: rtl/ahb_master_if.sv
// AHB master bridge: turns one local burst command at a time into pipelined
// NONSEQ/SEQ address phases with HREADY stalls, wrap addressing and ERROR abort.
//
// state | meaning
// IDLE  | ready for a command
// ADDR  | NONSEQ address phase of the first beat on the bus
// BURST | SEQ address phase, previous beat in its data phase
// LAST  | final data phase, address bus IDLE
// ERR   | second cycle of an ERROR response
module ahb_master_if #(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [AHB_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [2:0]                cmd_burst_in,
  input  logic [4:0]                cmd_len_in,
  input  logic [2:0]                cmd_size_in,
  input  logic                      cmd_write_in,
  input  logic [AHB_DATA_WIDTH-1:0] wdata_in,
  output logic                      wdata_ack_out,
  output logic [AHB_DATA_WIDTH-1:0] rdata_out,
  output logic                      rdata_valid_out,
  output logic                      done_out,
  output logic                      error_out,
  output logic                      ahb_sel_out,
  output logic [AHB_ADDR_WIDTH-1:0] ahb_addr_out,
  output logic [2:0]                ahb_burst_out,
  output logic [2:0]                ahb_size_out,
  output logic [1:0]                ahb_trans_out,
  output logic                      ahb_write_out,
  output logic [AHB_DATA_WIDTH-1:0] ahb_wdata_out,
  input  logic                      ahb_ready_in,
  input  logic                      ahb_resp_in,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_rdata_in
);

  localparam int AW = AHB_ADDR_WIDTH;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;
  state_t state, state_nxt;

  logic [4:0]    addr_cnt, data_cnt, beats;
  logic [4:0]    cmd_beats;
  logic          cmd_reject;
  logic [AW-1:0] cmd_bytes, cmd_end;
  logic [AW-1:0] incr, mask, next_addr;
  logic          wrap;
  logic          accept, addr_done, data_ok, err_first, err_end, finish_ok;

  always_comb begin
    case (cmd_burst_in)
      3'd0:       cmd_beats = 5'd1;
      3'd1: begin
        if (cmd_len_in == 5'd0)       cmd_beats = 5'd1;
        else if (cmd_len_in > 5'd16)  cmd_beats = 5'd16;
        else                          cmd_beats = cmd_len_in;
      end
      3'd2, 3'd3: cmd_beats = 5'd4;
      3'd4, 3'd5: cmd_beats = 5'd8;
      default:    cmd_beats = 5'd16;
    endcase
    cmd_bytes = AW'(cmd_beats) << cmd_size_in;
    cmd_end   = cmd_addr_in + cmd_bytes - AW'(1);
    // Odd HBURST codes are the incrementing types that must stay inside 1 KB.
    cmd_reject = ((32'd8 << cmd_size_in) > 32'(AHB_DATA_WIDTH))
              || ((cmd_addr_in & ((AW'(1) << cmd_size_in) - AW'(1))) != '0)
              || (cmd_burst_in[0] && ((cmd_end >> 10) != (cmd_addr_in >> 10)));
  end

  assign wrap      = (ahb_burst_out != 3'd0) && !ahb_burst_out[0];
  assign incr      = AW'(1) << ahb_size_out;
  assign mask      = (AW'(beats) << ahb_size_out) - AW'(1);
  assign next_addr = wrap ? ((ahb_addr_out & ~mask) | ((ahb_addr_out + incr) & mask))
                          : (ahb_addr_out + incr);

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && !cmd_reject) state_nxt = S_ADDR;
      S_ADDR, S_BURST: begin
        if (err_first)      state_nxt = S_ERR;
        else if (err_end)   state_nxt = S_IDLE;
        else if (addr_done) state_nxt = (addr_cnt > 5'd1) ? S_BURST : S_LAST;
      end
      S_LAST: begin
        if (err_first)                 state_nxt = S_ERR;
        else if (err_end || finish_ok) state_nxt = S_IDLE;
      end
      S_ERR:   if (err_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    addr_done = 1'b0;
    data_ok   = 1'b0;
    err_first = 1'b0;
    err_end   = 1'b0;
    finish_ok = 1'b0;
    case (state)
      S_IDLE: accept = cmd_valid_in;
      S_ADDR: addr_done = ahb_ready_in;
      S_BURST: begin
        if (ahb_resp_in) begin
          err_first = !ahb_ready_in;
          err_end   = ahb_ready_in;
        end else begin
          addr_done = ahb_ready_in;
          data_ok   = ahb_ready_in;
        end
      end
      S_LAST: begin
        if (ahb_resp_in) begin
          err_first = !ahb_ready_in;
          err_end   = ahb_ready_in;
        end else begin
          data_ok   = ahb_ready_in;
          finish_ok = ahb_ready_in;
        end
      end
      S_ERR:   err_end = ahb_ready_in;
      default: ;
    endcase
  end

  assign cmd_ready_out = (state == S_IDLE);
  assign wdata_ack_out = addr_done && ahb_write_out;

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      ahb_sel_out     <= 1'b0;
      ahb_addr_out    <= '0;
      ahb_burst_out   <= '0;
      ahb_size_out    <= '0;
      ahb_trans_out   <= TR_IDLE;
      ahb_write_out   <= 1'b0;
      ahb_wdata_out   <= '0;
      rdata_out       <= '0;
      rdata_valid_out <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
      beats           <= '0;
      addr_cnt        <= '0;
      data_cnt        <= '0;
    end else begin
      rdata_valid_out <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
      if (accept) begin
        if (cmd_reject) begin
          done_out  <= 1'b1;
          error_out <= 1'b1;
        end else begin
          ahb_sel_out   <= 1'b1;
          ahb_trans_out <= TR_NONSEQ;
          ahb_addr_out  <= cmd_addr_in;
          ahb_burst_out <= cmd_burst_in;
          ahb_size_out  <= cmd_size_in;
          ahb_write_out <= cmd_write_in;
          beats         <= cmd_beats;
          addr_cnt      <= cmd_beats;
          data_cnt      <= cmd_beats;
        end
      end
      if (addr_done) begin
        if (ahb_write_out) ahb_wdata_out <= wdata_in;
        if (addr_cnt > 5'd1) begin
          ahb_trans_out <= TR_SEQ;
          ahb_addr_out  <= next_addr;
        end else begin
          ahb_trans_out <= TR_IDLE;
        end
        if (addr_cnt != 5'd0) addr_cnt <= addr_cnt - 5'd1;
      end
      if (data_ok) begin
        if (data_cnt != 5'd0) data_cnt <= data_cnt - 5'd1;
        if (!ahb_write_out) begin
          rdata_out       <= ahb_rdata_in;
          rdata_valid_out <= 1'b1;
        end
      end
      if (finish_ok) begin
        done_out    <= 1'b1;
        ahb_sel_out <= 1'b0;
      end
      if (err_first) ahb_trans_out <= TR_IDLE;
      if (err_end) begin
        done_out      <= 1'b1;
        error_out     <= 1'b1;
        ahb_sel_out   <= 1'b0;
        ahb_trans_out <= TR_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_if.sv
// Bench for ahb_master_if: directed and random commands against an AHB slave
// model that predicts addresses, beats, data and completion from burst rules.
module tb_ahb_master_if;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [2:0]    cmd_burst = '0;
  logic [4:0]    cmd_len = '0;
  logic [2:0]    cmd_size = '0;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wdata_ack;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          done;
  logic          error;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [2:0]    hburst;
  logic [2:0]    hsize;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [DW-1:0] hwdata;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;
  logic [DW-1:0] hrdata = '0;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahb_master_if #(.AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW)) dut (
    .ahb_clk_in(clk), .ahb_rstn_in(rstn),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_addr_in(cmd_addr), .cmd_burst_in(cmd_burst), .cmd_len_in(cmd_len),
    .cmd_size_in(cmd_size), .cmd_write_in(cmd_write),
    .wdata_in(wdata), .wdata_ack_out(wdata_ack),
    .rdata_out(rdata), .rdata_valid_out(rdata_valid),
    .done_out(done), .error_out(error),
    .ahb_sel_out(hsel), .ahb_addr_out(haddr), .ahb_burst_out(hburst),
    .ahb_size_out(hsize), .ahb_trans_out(htrans), .ahb_write_out(hwrite),
    .ahb_wdata_out(hwdata), .ahb_ready_in(hready), .ahb_resp_in(hresp),
    .ahb_rdata_in(hrdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_beats(input logic [2:0] burst, input logic [4:0] len);
    case (burst)
      3'd0: return 1;
      3'd1: return (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic bit model_reject(input logic [31:0] addr, input logic [2:0] burst,
                                      input logic [4:0] len, input logic [2:0] size);
    longint bytes = longint'(1) << size;
    longint a = longint'(addr);
    if (bytes * 8 > DW) return 1'b1;
    if (a % bytes != 0) return 1'b1;
    if ((burst == 3'd1 || burst == 3'd3 || burst == 3'd5 || burst == 3'd7) &&
        (a / 1024 != (a + model_beats(burst, len) * bytes - 1) / 1024)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] addr, input logic [2:0] burst,
                                            input logic [4:0] len, input logic [2:0] size,
                                            input int k);
    longint bytes = longint'(1) << size;
    longint total = model_beats(burst, len) * bytes;
    longint a = longint'(addr);
    longint base;
    if (burst == 3'd2 || burst == 3'd4 || burst == 3'd6) begin
      base = a - (a % total);
      return 32'(base + (a - base + k * bytes) % total);
    end
    return 32'(a + k * bytes);
  endfunction

  // Issues one command and plays the slave; rst_at >= 0 pulls reset at that cycle.
  task automatic run_cmd(input logic [31:0] addr, input logic [2:0] burst, input logic [4:0] len,
                         input logic [2:0] size, input logic wr, input int err_beat,
                         input int wait_mode, input int rst_at);
    int beats, na, nd, cyc, acks, rvs, exp_rvs, waits_used;
    bit rej, aborted, in_err, finished, addr_act, data_pend, exp_done, exp_err, exp_rv;
    logic r, s;
    logic [31:0] rd, wd, exp_rd;
    logic [31:0] exp_wd [16];
    beats = model_beats(burst, len);
    rej = model_reject(addr, burst, len, size);
    na = 0; nd = 0; cyc = 0; acks = 0; rvs = 0; exp_rvs = 0; waits_used = 0;
    aborted = 0; in_err = 0; exp_rd = '0;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_burst = burst; cmd_len = len;
    cmd_size = size; cmd_write = wr; hready = 1'b1; hresp = 1'b0;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_done = rej; exp_err = rej; exp_rv = 0; finished = rej;
    forever begin
      chk("done", done, exp_done);
      if (exp_done) chk("error", error, exp_err);
      chk("rdata_valid", rdata_valid, exp_rv);
      if (exp_rv) chk("rdata", rdata, exp_rd);
      if (rdata_valid) rvs++;
      if (finished) begin
        chk("sel_end", hsel, 0);
        chk("trans_end", htrans, 0);
        break;
      end
      addr_act = !aborted && (na < beats);
      data_pend = !in_err && (nd < na);
      chk("sel", hsel, 1);
      if (addr_act) begin
        chk("trans", htrans, (na == 0) ? 2 : 3);
        chk("haddr", haddr, model_addr(addr, burst, len, size, na));
        chk("hburst", hburst, burst);
        chk("hsize", hsize, size);
        chk("hwrite", hwrite, wr);
      end else begin
        chk("trans_idle", htrans, 0);
      end
      if (data_pend && wr) chk("hwdata", hwdata, exp_wd[nd]);
      if (rst_at >= 0 && cyc == rst_at) begin
        rstn = 1'b0;
        #1;
        chk("rst_sel", hsel, 0);
        chk("rst_trans", htrans, 0);
        chk("rst_done", done, 0);
        cmd_valid = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_no_done", done, 0);
        @(posedge clk); #1;
        chk("rst_no_done2", done, 0);
        return;
      end
      r = 1'b1; s = 1'b0;
      if (in_err) begin
        s = 1'b1;
      end else if (data_pend && nd == err_beat) begin
        r = 1'b0; s = 1'b1;
      end else if (wait_mode == 1) begin
        r = ($urandom_range(0, 3) != 0);
      end else if (wait_mode == 2 && addr_act && na == 1 && waits_used < 2) begin
        r = 1'b0; waits_used++;
      end
      rd = $urandom; wd = $urandom;
      hready = r; hresp = s; hrdata = rd; wdata = wd;
      cmd_valid = 1'($urandom_range(0, 1)); cmd_addr = $urandom;
      #1;
      chk("wdata_ack", wdata_ack, wr && addr_act && r && !(data_pend && s));
      if (wdata_ack) acks++;
      exp_done = 0; exp_err = 0; exp_rv = 0;
      if (in_err) begin
        if (r) begin exp_done = 1; exp_err = 1; finished = 1; end
      end else if (data_pend && s) begin
        in_err = 1; aborted = 1;
      end else begin
        if (data_pend && r) begin
          nd++;
          if (!wr) begin exp_rv = 1; exp_rd = rd; exp_rvs++; end
          if (nd == beats) begin exp_done = 1; finished = 1; end
        end
        if (addr_act && r) begin
          exp_wd[na] = wd;
          na++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400) begin
        chk("timeout", 0, 1);
        break;
      end
    end
    cmd_valid = 1'b0; hready = 1'b1; hresp = 1'b0;
    chk("rvalid_count", rvs, exp_rvs);
    chk("wack_count", acks, wr ? na : 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  b, sz;
    logic [4:0]  ln;
    int          eb;
    #12;
    chk("reset_sel", hsel, 0);
    chk("reset_trans", htrans, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    run_cmd(32'h100, 3'd0, 5'd0, 3'd2, 1'b0, -1, 0, -1);
    run_cmd(32'h200, 3'd3, 5'd0, 3'd2, 1'b1, -1, 2, -1);
    run_cmd(32'h01C, 3'd4, 5'd0, 3'd2, 1'b0, -1, 0, -1);
    run_cmd(32'h038, 3'd2, 5'd0, 3'd2, 1'b1, -1, 1, -1);
    run_cmd(32'h300, 3'd5, 5'd0, 3'd2, 1'b0, 1, 0, -1);
    run_cmd(32'h000, 3'd0, 5'd0, 3'd3, 1'b0, -1, 0, -1);
    run_cmd(32'h3F8, 3'd7, 5'd0, 3'd2, 1'b0, -1, 0, -1);
    run_cmd(32'h102, 3'd1, 5'd3, 3'd2, 1'b1, -1, 0, -1);
    run_cmd(32'h3F0, 3'd1, 5'd4, 3'd2, 1'b0, -1, 1, -1);
    run_cmd(32'h400, 3'd1, 5'd10, 3'd2, 1'b0, -1, 0, 4);
    run_cmd(32'h080, 3'd1, 5'd0, 3'd1, 1'b1, -1, 1, -1);

    for (int i = 0; i < 40; i++) begin
      b  = 3'($urandom_range(0, 7));
      sz = 3'($urandom_range(0, 3));
      ln = 5'($urandom_range(0, 20));
      a  = $urandom_range(0, 4095);
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, model_beats(b, ln) - 1)) : -1;
      run_cmd(a, b, ln, sz, 1'($urandom_range(0, 1)), eb, 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
